// File: rtl/input_arbiter_if.sv
// ----------------------------------------------------------------------------
// input_arbiter_if
// Purpose : bundles the per-frame api levels coming from the ps2 decoder and
//           the per-frame player commands going to game logic.
// Signals : frame_tick          1-cycle frame strobe
//           api_esc             api[0][RST] level
//           api_kbd1/2, mouse   6-bit api levels {DN_SW, UP_SW, RIGHT, LEFT, JUMP, RST}
//           p1_cmd, p2_cmd      {down_sw, up_sw, right, left, jump}
//           cmd_valid           1-cycle strobe, commands updated
//           p2_owner            0 IDLE, 1 KBD, 2 MOUSE
//           game_rst            1-cycle pulse on ESC rising edge
// Modports: master drives the api side (decoder / testbench),
//           slave is the arbiter.
// ----------------------------------------------------------------------------
interface input_arbiter_if;
    logic       frame_tick;
    logic       api_esc;
    logic [5:0] api_kbd1;
    logic [5:0] api_kbd2;
    logic [5:0] api_mouse;
    logic [4:0] p1_cmd;
    logic [4:0] p2_cmd;
    logic       cmd_valid;
    logic [1:0] p2_owner;
    logic       game_rst;

    modport master (
        output frame_tick, api_esc, api_kbd1, api_kbd2, api_mouse,
        input  p1_cmd, p2_cmd, cmd_valid, p2_owner, game_rst
    );

    modport slave (
        input  frame_tick, api_esc, api_kbd1, api_kbd2, api_mouse,
        output p1_cmd, p2_cmd, cmd_valid, p2_owner, game_rst
    );
endinterface

// File: rtl/input_arbiter.sv
// ----------------------------------------------------------------------------
// input_arbiter
// Purpose : turns level key states into frame-aligned player commands.
//           P1 comes from keyboard group 1. P2 comes from keyboard group 2 or
//           the mouse/gyro group, whichever owns P2. Moves are levels, jumps
//           are one-shot, swings are one-shot and rate limited by a per-player
//           cooldown. ESC rising produces a one-shot game reset request.
// Ports   : clk    system clock
//           rst_n  async active-low reset
//           bus    input_arbiter_if.slave (api levels in, commands out)
// Params  : COOLDOWN    frames swings stay blocked after a swing fires (>=1)
//           HOLD_FRAMES idle frames before the P2 owner releases (>=1)
// Config  : P2_MOUSE_ARB_EN defined   -> P2 arbitrated between kbd2 and mouse.
//           P2_MOUSE_ARB_EN undefined -> P2 always follows kbd2, mouse ignored.
// ----------------------------------------------------------------------------
module input_arbiter #(
    parameter int COOLDOWN    = 6,
    parameter int HOLD_FRAMES = 30
) (
    input logic            clk,
    input logic            rst_n,
    input_arbiter_if.slave bus
);
    localparam int CD_W   = $clog2(COOLDOWN + 1);
    localparam int IDLE_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_KBD   = 2'd1,
        OWN_MOUSE = 2'd2
    } owner_e;

    typedef struct packed {
        logic [4:0] cmd;
        logic       fire;
    } decode_t;

    // One source's command for this frame. cur/prev are bits 5..1 of the api
    // levels (RST bit excluded). swing_ok is the player's cooldown==0.
    function automatic decode_t decode(input logic [5:1] cur,
                                       input logic [5:1] prev,
                                       input logic       swing_ok);
        logic [5:1] rise;
        decode_t    res;
        rise         = cur & ~prev;
        res          = '0;
        res.cmd[0]   = rise[1];
        res.cmd[1]   = cur[2] & ~cur[3];   // LEFT+RIGHT cancel
        res.cmd[2]   = cur[3] & ~cur[2];
        if (swing_ok) begin
            if (rise[4]) begin            // UP wins over a simultaneous DOWN
                res.cmd[3] = 1'b1;
                res.fire   = 1'b1;
            end else if (rise[5]) begin
                res.cmd[4] = 1'b1;
                res.fire   = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [CD_W-1:0] cd_next(input logic [CD_W-1:0] cd,
                                                input logic            fire);
        if (fire)
            return CD_LOAD;
        if (cd != '0)
            return cd - CD_W'(1);
        return cd;
    endfunction

    logic            hist_esc_q,  hist_esc_d;
    logic [5:1]      hist_kbd1_q, hist_kbd1_d;
    logic [5:1]      hist_kbd2_q, hist_kbd2_d;
    logic [CD_W-1:0] cd1_q, cd1_d;
    logic [CD_W-1:0] cd2_q, cd2_d;
    owner_e          owner_q, owner_d;
    logic [4:0]      p1_cmd_q, p1_cmd_d;
    logic [4:0]      p2_cmd_q, p2_cmd_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            game_rst_q, game_rst_d;
`ifdef P2_MOUSE_ARB_EN
    logic [5:1]        hist_mouse_q, hist_mouse_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              kbd2_act, mouse_act, own_act;
`endif

    logic [5:1] p2_src;
    logic [5:1] p2_prev;
    logic       p2_en;
    decode_t    dec1, dec2;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        hist_esc_d  = hist_esc_q;
        hist_kbd1_d = hist_kbd1_q;
        hist_kbd2_d = hist_kbd2_q;
        cd1_d       = cd1_q;
        cd2_d       = cd2_q;
        owner_d     = owner_q;
        p1_cmd_d    = p1_cmd_q;
        p2_cmd_d    = p2_cmd_q;
        cmd_valid_d = 1'b0;
        game_rst_d  = 1'b0;
        p2_src      = '0;
        p2_prev     = '0;
        p2_en       = 1'b0;
        dec1        = '0;
        dec2        = '0;
`ifdef P2_MOUSE_ARB_EN
        hist_mouse_d = hist_mouse_q;
        idle_cnt_d   = idle_cnt_q;
        kbd2_act     = |bus.api_kbd2[5:1];
        mouse_act    = |bus.api_mouse[5:1];
        own_act      = 1'b0;
`else
        // Without arbitration kbd2 owns P2 from the first clock after reset.
        owner_d      = OWN_KBD;
`endif

        if (bus.frame_tick) begin
            cmd_valid_d = 1'b1;
            game_rst_d  = bus.api_esc & ~hist_esc_q;
            // History tracks every source every frame, owner or not.
            hist_esc_d  = bus.api_esc;
            hist_kbd1_d = bus.api_kbd1[5:1];
            hist_kbd2_d = bus.api_kbd2[5:1];

            dec1     = decode(bus.api_kbd1[5:1], hist_kbd1_q, cd1_q == '0);
            p1_cmd_d = dec1.cmd;
            cd1_d    = cd_next(cd1_q, dec1.fire);

`ifdef P2_MOUSE_ARB_EN
            hist_mouse_d = bus.api_mouse[5:1];
            case (owner_q)
                OWN_IDLE: begin
                    idle_cnt_d = '0;
                    if (kbd2_act)
                        owner_d = OWN_KBD;
                    else if (mouse_act)
                        owner_d = OWN_MOUSE;
                end
                OWN_KBD, OWN_MOUSE: begin
                    own_act = (owner_q == OWN_KBD) ? kbd2_act : mouse_act;
                    if (own_act)
                        idle_cnt_d = '0;
                    else if (idle_cnt_q != IDLE_W'(HOLD_FRAMES))
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    if (idle_cnt_d == IDLE_W'(HOLD_FRAMES)) begin
                        owner_d    = OWN_IDLE;
                        idle_cnt_d = '0;
                    end
                end
                default: begin
                    owner_d    = OWN_IDLE;
                    idle_cnt_d = '0;
                end
            endcase
            // The owner granted this frame already drives this frame's command.
            if (owner_d == OWN_KBD) begin
                p2_src  = bus.api_kbd2[5:1];
                p2_prev = hist_kbd2_q;
                p2_en   = 1'b1;
            end else if (owner_d == OWN_MOUSE) begin
                p2_src  = bus.api_mouse[5:1];
                p2_prev = hist_mouse_q;
                p2_en   = 1'b1;
            end
`else
            p2_src  = bus.api_kbd2[5:1];
            p2_prev = hist_kbd2_q;
            p2_en   = 1'b1;
`endif
            if (p2_en)
                dec2 = decode(p2_src, p2_prev, cd2_q == '0);
            p2_cmd_d = dec2.cmd;                  // zero while IDLE
            cd2_d    = cd_next(cd2_q, dec2.fire); // per player, survives owner change
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_esc_q   <= 1'b0;
            hist_kbd1_q  <= '0;
            hist_kbd2_q  <= '0;
            cd1_q        <= '0;
            cd2_q        <= '0;
            owner_q      <= OWN_IDLE;
            p1_cmd_q     <= '0;
            p2_cmd_q     <= '0;
            cmd_valid_q  <= 1'b0;
            game_rst_q   <= 1'b0;
`ifdef P2_MOUSE_ARB_EN
            hist_mouse_q <= '0;
            idle_cnt_q   <= '0;
`endif
        end else begin
            hist_esc_q   <= hist_esc_d;
            hist_kbd1_q  <= hist_kbd1_d;
            hist_kbd2_q  <= hist_kbd2_d;
            cd1_q        <= cd1_d;
            cd2_q        <= cd2_d;
            owner_q      <= owner_d;
            p1_cmd_q     <= p1_cmd_d;
            p2_cmd_q     <= p2_cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            game_rst_q   <= game_rst_d;
`ifdef P2_MOUSE_ARB_EN
            hist_mouse_q <= hist_mouse_d;
            idle_cnt_q   <= idle_cnt_d;
`endif
        end
    end

    assign bus.p1_cmd    = p1_cmd_q;
    assign bus.p2_cmd    = p2_cmd_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.p2_owner  = owner_q;
    assign bus.game_rst  = game_rst_q;
endmodule

// File: tb/tb_input_arbiter.sv
// ----------------------------------------------------------------------------
// tb_input_arbiter
// Self-checking bench for input_arbiter. Main DUT uses COOLDOWN=6,
// HOLD_FRAMES=30; a second DUT with HOLD_FRAMES=2 shares the same stimulus so
// a P2 owner change can happen while the P2 swing cooldown is still running.
// Expectations adapt to whether P2_MOUSE_ARB_EN is defined.
// ----------------------------------------------------------------------------
module tb_input_arbiter;
`ifdef P2_MOUSE_ARB_EN
    localparam bit ARB = 1'b1;
`else
    localparam bit ARB = 1'b0;
`endif
    // Owner of P2 when nothing has claimed it yet.
    localparam logic [1:0] O_FREE = ARB ? 2'd0 : 2'd1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    input_arbiter_if bus();
    input_arbiter_if bus_s();

    assign bus_s.frame_tick = bus.frame_tick;
    assign bus_s.api_esc    = bus.api_esc;
    assign bus_s.api_kbd1   = bus.api_kbd1;
    assign bus_s.api_kbd2   = bus.api_kbd2;
    assign bus_s.api_mouse  = bus.api_mouse;

    input_arbiter #(.COOLDOWN(6), .HOLD_FRAMES(30)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    input_arbiter #(.COOLDOWN(6), .HOLD_FRAMES(2)) u_dut_s (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_s.slave)
    );

    typedef struct {
        logic [5:0] kbd1, kbd2, mouse;
        logic       esc;
        logic [4:0] p1, p2;
        logic [1:0] own;
        logic       grst;
        logic       chk_s;
        logic [4:0] s_p2;
        logic [1:0] s_own;
    } vec_t;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t sb_q[$];
    vec_t last;
    bit   have_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic [5:0] kbd1, kbd2, mouse, input logic esc,
                                input logic [4:0] p1, p2, input logic [1:0] own,
                                input logic grst);
        vec_t v;
        v.kbd1 = kbd1; v.kbd2 = kbd2; v.mouse = mouse; v.esc = esc;
        v.p1 = p1; v.p2 = p2; v.own = own; v.grst = grst;
        v.chk_s = 1'b0; v.s_p2 = '0; v.s_own = '0;
        return v;
    endfunction

    function automatic vec_t mks(input logic [5:0] kbd1, kbd2, mouse,
                                 input logic [4:0] p1, p2, input logic [1:0] own,
                                 input logic [4:0] s_p2, input logic [1:0] s_own);
        vec_t v;
        v = mk(kbd1, kbd2, mouse, 1'b0, p1, p2, own, 1'b0);
        v.chk_s = 1'b1; v.s_p2 = s_p2; v.s_own = s_own;
        return v;
    endfunction

    // One frame: verify the idle cycle held the outputs, drive a tick, then
    // compare the registered result one cycle later against the scoreboard.
    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        if (have_last) begin
            check({tag, " idle cmd_valid"}, bus.cmd_valid, 0);
            check({tag, " hold p1"}, bus.p1_cmd, last.p1);
            check({tag, " hold p2"}, bus.p2_cmd, last.p2);
            check({tag, " idle game_rst"}, bus.game_rst, 0);
        end
        bus.api_kbd1   = v.kbd1;
        bus.api_kbd2   = v.kbd2;
        bus.api_mouse  = v.mouse;
        bus.api_esc    = v.esc;
        bus.frame_tick = 1'b1;
        sb_q.push_back(v);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        check({tag, " cmd_valid"}, bus.cmd_valid, 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, " p1_cmd"}, bus.p1_cmd, e.p1);
            check({tag, " p2_cmd"}, bus.p2_cmd, e.p2);
            check({tag, " p2_owner"}, bus.p2_owner, e.own);
            check({tag, " game_rst"}, bus.game_rst, e.grst);
            if (e.chk_s) begin
                check({tag, " s.p2_cmd"}, bus_s.p2_cmd, e.s_p2);
                check({tag, " s.p2_owner"}, bus_s.p2_owner, e.s_own);
            end
            last      = e;
            have_last = 1'b1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " p1_cmd"}, bus.p1_cmd, 0);
        check({tag, " p2_cmd"}, bus.p2_cmd, 0);
        check({tag, " p2_owner"}, bus.p2_owner, 0);
        check({tag, " cmd_valid"}, bus.cmd_valid, 0);
        check({tag, " game_rst"}, bus.game_rst, 0);
        check({tag, " s.p2_owner"}, bus_s.p2_owner, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tab_a[11];
        vec_t tab_d[9];
        vec_t v;
        logic [1:0] own;

        // Basic P1 behaviour and ESC, from a fresh reset.
        tab_a[0]  = mk(6'b000010, 0, 0, 0, 5'b00001, 0, O_FREE, 0); // jump rising
        tab_a[1]  = mk(6'b000010, 0, 0, 0, 5'b00000, 0, O_FREE, 0); // held
        tab_a[2]  = mk(6'b000010, 0, 0, 0, 5'b00000, 0, O_FREE, 0);
        tab_a[3]  = mk(6'b001100, 0, 0, 0, 5'b00000, 0, O_FREE, 0); // L+R cancel
        tab_a[4]  = mk(6'b000100, 0, 0, 0, 5'b00010, 0, O_FREE, 0); // left
        tab_a[5]  = mk(6'b001000, 0, 0, 0, 5'b00100, 0, O_FREE, 0); // right
        tab_a[6]  = mk(6'b000000, 0, 0, 1, 5'b00000, 0, O_FREE, 1); // ESC rise
        tab_a[7]  = mk(6'b000000, 0, 0, 1, 5'b00000, 0, O_FREE, 0); // ESC held
        tab_a[8]  = mk(6'b000000, 0, 0, 0, 5'b00000, 0, O_FREE, 0);
        tab_a[9]  = mk(6'b000000, 0, 0, 1, 5'b00000, 0, O_FREE, 1); // ESC again
        tab_a[10] = mk(6'b110000, 0, 0, 0, 5'b01000, 0, O_FREE, 0); // UP+DOWN -> UP

        // Small-hold DUT: P2 swing fired by kbd2, owner released after 2 idle
        // frames, mouse takes over while the cooldown still blocks it.
        tab_d[0] = mks(6'b000010, 0, 0, 5'b00001, 0, O_FREE, 0, O_FREE);
        tab_d[1] = mks(0, 6'b010000, 0, 0, 5'b01000, 1, 5'b01000, 1);
        tab_d[2] = mks(0, 0, 0, 0, 0, 1, 0, 1);
        tab_d[3] = mks(0, 0, 0, 0, 0, 1, 0, ARB ? 2'd0 : 2'd1);
        tab_d[4] = mks(0, 0, 6'b010000, 0, 0, 1, 0, ARB ? 2'd2 : 2'd1);
        tab_d[5] = mks(0, 0, 0, 0, 0, 1, 0, ARB ? 2'd2 : 2'd1);
        tab_d[6] = mks(0, 0, 6'b010000, 0, 0, 1, 0, ARB ? 2'd2 : 2'd1);
        tab_d[7] = mks(0, 0, 0, 0, 0, 1, 0, ARB ? 2'd2 : 2'd1);
        tab_d[8] = mks(0, 0, 6'b010000, 0, 0, 1, ARB ? 5'b01000 : 5'b00000,
                       ARB ? 2'd2 : 2'd1);

        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.api_esc    = 1'b0;
        bus.api_kbd1   = '0;
        bus.api_kbd2   = '0;
        bus.api_mouse  = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tab_a[i], $sformatf("A%0d", i));

        // Let P1 cooldown drain, then UP pulsed every 2 frames.
        for (int i = 0; i < 6; i++)
            run_vec(mk(0, 0, 0, 0, 0, 0, O_FREE, 0), $sformatf("drain%0d", i));
        for (int k = 0; k < 10; k++) begin
            v = mk((k % 2 == 0) ? 6'b010000 : 6'b000000, 0, 0, 0,
                   (k == 0 || k == 8) ? 5'b01000 : 5'b00000, 0, O_FREE, 0);
            run_vec(v, $sformatf("swing%0d", k));
        end

        // P2: simultaneous claim, mouse ignored while KBD owns, idle release.
        run_vec(mk(0, 6'b000100, 6'b001000, 0, 0, 5'b00010, 1, 0), "B0");
        for (int i = 1; i <= 30; i++) begin
            own = (ARB && i == 30) ? 2'd0 : 2'd1;
            v = mk(0, 0, (i <= 5) ? 6'b001000 : 6'b000000, 0, 0, 0, own, 0);
            run_vec(v, $sformatf("idle%0d", i));
        end
        run_vec(mk(0, 0, 6'b000100, 0, 0, ARB ? 5'b00010 : 5'b00000,
                   ARB ? 2'd2 : 2'd1, 0), "B31");
        run_vec(mk(0, 0, 6'b010100, 0, 0, ARB ? 5'b01010 : 5'b00000,
                   ARB ? 2'd2 : 2'd1, 0), "B32");
        run_vec(mk(0, 6'b000100, 0, 0, 0, ARB ? 5'b00000 : 5'b00010,
                   ARB ? 2'd2 : 2'd1, 0), "B33");

        // Jump held across a mid-frame reset rises again after release.
        run_vec(mk(6'b000010, 0, 0, 0, 5'b00001, 0, ARB ? 2'd2 : 2'd1, 0), "C0");
        run_vec(mk(6'b000010, 6'b000100, 6'b000100, 0, 0, 5'b00010,
                   ARB ? 2'd2 : 2'd1, 0), "C1");
        #2 rst_n = 1'b0;
        #1 check_reset("midreset");
        have_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(tab_d[i], $sformatf("D%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
